// File: rtl/sample_serializer_if.sv
// Sample-in / DAC-pins bundle for sample_serializer.
// The slave modport is the serializer's view; the master modport is the view of
// whatever drives samples and observes the DAC pins (the mixer side plus a monitor).
interface sample_serializer_if;
  logic [15:0] data_in;
  logic        data_valid_in;
  logic        bclk_out;
  logic        lrclk_out;
  logic        sdata_out;
  logic        frame_start_out;
  logic        overrun_out;

  modport slave (
    input  data_in,
    input  data_valid_in,
    output bclk_out,
    output lrclk_out,
    output sdata_out,
    output frame_start_out,
    output overrun_out
  );

  modport master (
    output data_in,
    output data_valid_in,
    input  bclk_out,
    input  lrclk_out,
    input  sdata_out,
    input  frame_start_out,
    input  overrun_out
  );
endinterface

// File: rtl/sample_serializer.sv
// Serial audio transmitter.
//
// A one-deep buffer holds the sample. The same 16-bit sample is sent MSB-first
// in both the left and the right slot of a 32-bit stereo frame.
// Define SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN to select the left-justified format
// (no 1-bit delay). Without it, the block uses I2S format.
module sample_serializer #(
  parameter int unsigned BCLK_DIV = 16
) (
  input logic                 clk_in,
  input logic                 reset_in,
  sample_serializer_if.slave  bus_io
);

  localparam int unsigned CntW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BCLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bclk_q, bclk_d;
  logic [4:0]      pos_q, pos_d;
  logic            lrclk_q, lrclk_d;
  logic            sdata_q, sdata_d;
  logic            frame_start_q, frame_start_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [15:0]     cur_q, cur_d;

  logic            tick;
  logic            fall_evt;
  logic            boundary;
  logic [3:0]      slot_k;
  logic [3:0]      bit_idx;

  // Divider terminal count and the events it creates.
  always_comb begin
    tick     = (cnt_q == CntMax);
    fall_evt = tick & bclk_q;
    boundary = fall_evt & (pos_q == 5'd31);
  end

  // Next-state for clocking, buffering and the serial output bit.
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    bclk_d        = tick ? ~bclk_q : bclk_q;
    pos_d         = fall_evt ? pos_q + 5'd1 : pos_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    cur_d         = cur_q;
    frame_start_d = boundary;
    overrun_d     = 1'b0;
    slot_k        = pos_d[3:0];
    bit_idx       = 4'd0;

    // At the frame boundary the held sample moves on. If no sample is held, the
    // current one repeats.
    if (boundary) begin
      if (hold_full_q) begin
        cur_d = hold_q;
      end
      hold_full_d = 1'b0;
    end

    // If a load and a write occur together, the old hold has already moved to
    // cur above. The write then refills hold, so this does not count as an overrun.
    if (bus_io.data_valid_in) begin
      hold_d      = bus_io.data_in;
      hold_full_d = 1'b1;
      overrun_d   = hold_full_q & ~boundary;
    end

    if (fall_evt) begin
      lrclk_d = pos_d[4];
`ifdef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
      bit_idx = 4'd15 - slot_k;
      sdata_d = cur_d[bit_idx];
`else
      // Offset 0 of each slot carries the LSB of the sample sent before it. At
      // pos 0 that is the previous frame's sample, so use the pre-load cur.
      bit_idx = 4'd0 - slot_k;
      sdata_d = (slot_k == 4'd0) ? cur_q[0] : cur_d[bit_idx];
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q         <= '0;
      bclk_q        <= 1'b0;
      pos_q         <= 5'd31;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      cur_q         <= '0;
    end else begin
      cnt_q         <= cnt_d;
      bclk_q        <= bclk_d;
      pos_q         <= pos_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      cur_q         <= cur_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    bus_io.bclk_out        = bclk_q;
    bus_io.lrclk_out       = lrclk_q;
    bus_io.sdata_out       = sdata_q;
    bus_io.frame_start_out = frame_start_q;
    bus_io.overrun_out     = overrun_q;
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer with BCLK_DIV = 16.
// A frame is 1024 cycles. After reset, frame f starts at cycle 32 + 1024*f.
// Within frame f, pos p occupies cycles 32 + 1024*f + 32*p through 32 + 1024*f + 32*p + 31.
module tb_sample_serializer;

  logic clk = 1'b0;
  logic rst;

  sample_serializer_if bus ();

  sample_serializer #(
    .BCLK_DIV (16)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus_io   (bus)
  );

  always #5 clk = ~clk;

`ifdef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
  localparam int Off = 0;
`else
  localparam int Off = 1;
`endif

  int n;
  int checks;
  int errors;
  int ov_cnt;
  int fs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; n then equals the cycle number.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (bus.overrun_out) ov_cnt++;
    if (bus.frame_start_out) fs_cnt++;
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  // Present a one-cycle strobe so that edge e samples it.
  task automatic strobe(input int e, input logic [15:0] d);
    run_to(e - 1);
    bus.data_in       = d;
    bus.data_valid_in = 1'b1;
    tick();
    bus.data_valid_in = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n   = 0;
  endtask

  function automatic logic [4:0] outs();
    return {bus.bclk_out, bus.lrclk_out, bus.sdata_out, bus.frame_start_out, bus.overrun_out};
  endfunction

  task automatic capture_frame(input int b, output logic [31:0] bits);
    bits = '0;
    for (int p = 0; p < 32; p++) begin
      run_to(b + 32 * p + 8);
      bits[p] = bus.sdata_out;
    end
  endtask

  // The first-slot word, MSB first, starts at pos Off.
  function automatic logic [15:0] slot_word(input logic [31:0] bits);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15 - i] = bits[Off + i];
    return w;
  endfunction

  // The first 15 bits of the second slot (sample[15:1]).
  function automatic logic [14:0] slot_tail(input logic [31:0] bits);
    logic [14:0] t;
    for (int i = 0; i < 15; i++) t[14 - i] = bits[16 + Off + i];
    return t;
  endfunction

  // Behaviour after reset with no writes.
  task automatic check_reset_timing(input string tag);
    int zero_pre, sd_ones, fs_first, fs_second, fs_n, ov0;
    logic b15, b16, b31, b32, lr40, lr600;
    zero_pre = 0; sd_ones = 0; fs_first = -1; fs_second = -1; fs_n = 0;
    b15 = 1'bx; b16 = 1'bx; b31 = 1'bx; b32 = 1'bx; lr40 = 1'bx; lr600 = 1'bx;
    ov0 = ov_cnt;
    check_eq({tag, "_reset_outs"}, 32'(outs()), 32'h0);
    while (n < 1060) begin
      tick();
      if (n < 16 && outs() != 5'd0) zero_pre++;
      if (n == 15) b15 = bus.bclk_out;
      if (n == 16) b16 = bus.bclk_out;
      if (n == 31) b31 = bus.bclk_out;
      if (n == 32) b32 = bus.bclk_out;
      if (n == 40) lr40 = bus.lrclk_out;
      if (n == 600) lr600 = bus.lrclk_out;
      if (bus.sdata_out) sd_ones++;
      if (bus.frame_start_out) begin
        if (fs_n == 0) fs_first = n;
        else if (fs_n == 1) fs_second = n;
        fs_n++;
      end
    end
    check_eq({tag, "_zero_before_16"}, 32'(zero_pre), 32'd0);
    check_eq({tag, "_bclk_15"}, 32'(b15), 32'd0);
    check_eq({tag, "_bclk_16"}, 32'(b16), 32'd1);
    check_eq({tag, "_bclk_31"}, 32'(b31), 32'd1);
    check_eq({tag, "_bclk_32"}, 32'(b32), 32'd0);
    check_eq({tag, "_fs_first"}, 32'(fs_first), 32'd32);
    check_eq({tag, "_fs_second"}, 32'(fs_second), 32'd1056);
    check_eq({tag, "_fs_count"}, 32'(fs_n), 32'd2);
    check_eq({tag, "_sdata_quiet"}, 32'(sd_ones), 32'd0);
    check_eq({tag, "_lrclk_left"}, 32'(lr40), 32'd0);
    check_eq({tag, "_lrclk_right"}, 32'(lr600), 32'd1);
    check_eq({tag, "_no_overrun"}, 32'(ov_cnt - ov0), 32'd0);
  endtask

  initial begin
    logic [31:0] bits;
    int ov_base;
    n = 0; checks = 0; errors = 0; ov_cnt = 0; fs_cnt = 0;
    bus.data_in       = '0;
    bus.data_valid_in = 1'b0;
    rst               = 1'b1;

    // Scenario 1: free-running with no writes.
    apply_reset();
    check_reset_timing("s1");

    // Scenario 2: write 0xA5C3 before the first boundary.
    apply_reset();
    strobe(5, 16'hA5C3);
    capture_frame(32, bits);
    check_eq("f0_slot0", 32'(slot_word(bits)), 32'h0000A5C3);
    check_eq("f0_slot1", 32'(slot_tail(bits)), 32'h000052E1);
`ifndef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
    check_eq("f0_pos0", 32'(bits[0]), 32'd0);
`endif

    // Scenario 3: no write, so frame 1 repeats the sample.
    capture_frame(1056, bits);
    check_eq("f1_slot0", 32'(slot_word(bits)), 32'h0000A5C3);
    check_eq("f1_slot1", 32'(slot_tail(bits)), 32'h000052E1);
`ifndef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
    check_eq("f1_pos0", 32'(bits[0]), 32'd1);
`endif

    // Scenario 4: two writes within frame 2 cause one overrun.
    ov_base = ov_cnt;
    strobe(2100, 16'h1111);
    check_eq("ov_first_write", 32'(bus.overrun_out), 32'd0);
    strobe(2200, 16'h2222);
    check_eq("ov_pulse", 32'(bus.overrun_out), 32'd1);
    tick();
    check_eq("ov_pulse_end", 32'(bus.overrun_out), 32'd0);
    run_to(3100);
    check_eq("ov_count", 32'(ov_cnt - ov_base), 32'd1);
    capture_frame(3104, bits);
    check_eq("f3_slot0", 32'(slot_word(bits)), 32'h00002222);
    check_eq("f3_slot1", 32'(slot_tail(bits)), 32'h00001111);
`ifndef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
    check_eq("f3_pos0", 32'(bits[0]), 32'd1);
`endif

    // Scenario 5: a write in the boundary cycle while hold is full.
    ov_base = ov_cnt;
    strobe(4110, 16'h8000);
    strobe(4128, 16'h7FFF);
    check_eq("bnd_frame_start", 32'(bus.frame_start_out), 32'd1);
    tick();
    check_eq("bnd_no_overrun", 32'(ov_cnt - ov_base), 32'd0);
    capture_frame(4128, bits);
    check_eq("f4_slot0", 32'(slot_word(bits)), 32'h00008000);
    check_eq("f4_slot1", 32'(slot_tail(bits)), 32'h00004000);
`ifndef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
    check_eq("f4_pos0", 32'(bits[0]), 32'd0);
`endif
    capture_frame(5152, bits);
    check_eq("f5_slot0", 32'(slot_word(bits)), 32'h00007FFF);
    check_eq("f5_slot1", 32'(slot_tail(bits)), 32'h00003FFF);
`ifndef SAMPLE_SERIALIZER_LEFT_JUSTIFY_EN
    check_eq("f5_pos0", 32'(bits[0]), 32'd0);
`endif

    // Scenario 6: a one-cycle reset at pos 20 of frame 6.
    run_to(6823);
    check_eq("pre_reset_lrclk", 32'(bus.lrclk_out), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("mid_reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    n   = 0;
    check_reset_timing("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
